rv_iter_muldiv: RTL

- Parametrised iterative RV M-extension unit for the ysyx_23060187 core. It replaces the single-cycle combinational `*`, `/` and `%` paths in the datapath.
- Executes all eight funct3 ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Uses radix-2 shift-add multiply and restoring division.
- Has valid/ready handshakes on both sides, so the core can stall on it. Produces full RISC-V-compliant results, including signed REM and the divide-by-zero and overflow cases.

---
 rtl/rv_iter_muldiv.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/rv_iter_muldiv.sv
// Iterative RISC-V M-extension unit: radix-2 shift-add multiply and restoring divide,
// valid/ready on both sides, with an optional single-cycle path for div-by-zero/overflow.
module rv_iter_muldiv #(
    parameter int unsigned XLEN         = 32,
    parameter bit          FAST_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy
);
    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_SIGNED = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     rem_q, rem_d;
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     res_q, res_d;

    logic                sa, sb, neg_in, b_zero, ovf, special;
    logic [XLEN-1:0]     a_mag, b_mag, special_res;
    logic [XLEN-1:0]     addend;
    logic [XLEN:0]       mul_sum, div_shift, div_trial;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     res_fix;

    assign in_ready   = (state_q == IDLE) && rst && !flush;
    assign out_valid  = (state_q == DONE);
    assign out_result = res_q;
    assign busy       = (state_q != IDLE);

    // Request decode: magnitudes, result sign and the special-case shortcut
    always_comb begin
        sa = 1'b0;
        sb = 1'b0;
        case (op_e'(in_op))
            OP_MULH, OP_DIV, OP_REM: begin
                sa = in_a[XLEN-1];
                sb = in_b[XLEN-1];
            end
            OP_MULHSU: sa = in_a[XLEN-1];
            default: ;
        endcase
        a_mag  = sa ? ('0 - in_a) : in_a;
        b_mag  = sb ? ('0 - in_b) : in_b;
        b_zero = (in_b == '0);
        ovf    = ((op_e'(in_op) == OP_DIV) || (op_e'(in_op) == OP_REM))
                 && (in_a == MIN_SIGNED) && (in_b == '1);
        case (op_e'(in_op))
            OP_MULH, OP_MULHSU, OP_DIV: neg_in = sa ^ sb;
            OP_REM:                     neg_in = sa;
            default:                    neg_in = 1'b0;
        endcase
        // Signed divide by zero must yield all-ones, so the quotient is never negated
        if ((op_e'(in_op) == OP_DIV) && b_zero)
            neg_in = 1'b0;
        special = FAST_SPECIAL && in_op[2] && (b_zero || ovf);
        if (b_zero)
            special_res = in_op[1] ? in_a : '1;
        else
            special_res = in_op[1] ? '0 : MIN_SIGNED;
    end

    // One iteration of each datapath plus the sign fix-up
    always_comb begin
        addend    = acc_q[0] ? a_q : '0;
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, addend};
        div_shift = {rem_q, acc_q[XLEN-1]};
        div_trial = div_shift - {1'b0, b_q};
        prod_fix  = neg_q ? ('0 - acc_q) : acc_q;
        case (op_e'(op_q))
            OP_MUL:                        res_fix = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  res_fix = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               res_fix = neg_q ? ('0 - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
            default:                       res_fix = neg_q ? ('0 - rem_q) : rem_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        neg_d   = neg_q;
        res_d   = res_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        op_d  = in_op;
                        a_d   = a_mag;
                        b_d   = b_mag;
                        neg_d = neg_in;
                        cnt_d = '0;
                        rem_d = '0;
                        // Low half holds the multiplier for MUL ops, the dividend for DIV ops
                        acc_d = {{XLEN{1'b0}}, (in_op[2] ? a_mag : b_mag)};
                        if (special) begin
                            res_d   = special_res;
                            state_d = DONE;
                        end else begin
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    if (op_q[2]) begin
                        rem_d = div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
                        acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~div_trial[XLEN]};
                    end else begin
                        acc_d = {mul_sum, acc_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN - 1)) begin
                        cnt_d   = '0;
                        state_d = FIX;
                    end
                end
                FIX: begin
                    res_d   = res_fix;
                    state_d = DONE;
                end
                DONE: begin
                    if (out_ready)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            neg_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
        end
    end
endmodule
